debouncer: RTL and testbench

// Cleans a raw, asynchronous, bouncing input (push button or switch) into a single-clock-domain level.

---
 rtl/debouncer.sv | 122 ++++++++++++
 tb/tb_debouncer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/debouncer.sv
// Debouncer: synchronizer chain feeding a four-state qualification FSM, with a
// saturating counter of aborted qualifications.
module debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BOUNCE_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in,
  input  logic                clear,
  output logic                out,
  output logic                stable,
  output logic [BOUNCE_W-1:0] bounce_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   stable_q, stable_d;
  logic [BOUNCE_W-1:0]    bounce_q, bounce_d;
  logic                   in_sync;
  logic                   abort;

  assign in_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], in};
    state_d  = state_q;
    cnt_d    = cnt_q;
    abort    = 1'b0;
    case (state_q)
      S_LOW: begin
        if (in_sync) begin
          state_d = S_RISE;
          cnt_d   = CNT_ONE;
        end
      end
      S_RISE: begin
        if (!in_sync) begin
          state_d = S_LOW;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!in_sync) begin
          state_d = S_FALL;
          cnt_d   = CNT_ONE;
        end
      end
      S_FALL: begin
        if (in_sync) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase

    // Outputs decode the next state so they land in the same cycle as the state.
    out_d    = (state_d == S_HIGH) || (state_d == S_FALL);
    stable_d = (state_d == S_LOW) || (state_d == S_HIGH);

    if (clear) begin
      bounce_d = '0;
    end else if (abort && (bounce_q != {BOUNCE_W{1'b1}})) begin
      bounce_d = bounce_q + BOUNCE_W'(1);
    end else begin
      bounce_d = bounce_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q   <= '0;
      state_q  <= S_LOW;
      cnt_q    <= '0;
      out_q    <= 1'b0;
      stable_q <= 1'b1;
      bounce_q <= '0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      stable_q <= stable_d;
      bounce_q <= bounce_d;
    end
  end

  assign out          = out_q;
  assign stable       = stable_q;
  assign bounce_count = bounce_q;

endmodule

// File: tb/tb_debouncer.sv
// Bench for debouncer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, BOUNCE_W=2): per-cycle
// vectors with hand-derived expectations, checked through an expected-value queue.
module tb_debouncer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_r = 1'b0;
  logic       clear_r = 1'b0;
  logic       out;
  logic       stable;
  logic [1:0] bc;

  always #5 clk = ~clk;

  debouncer #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .BOUNCE_W(2)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .in(in_r),
    .clear(clear_r),
    .out(out),
    .stable(stable),
    .bounce_count(bc)
  );

  typedef struct {
    logic       i;
    logic       c;
    logic       r;
    logic       eo;
    logic       es;
    logic [1:0] eb;
  } vec_t;

  typedef struct {
    logic       eo;
    logic       es;
    logic [1:0] eb;
    int         id;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  task automatic add(input logic i, input logic c, input logic r,
                     input logic eo, input logic es, input logic [1:0] eb);
    vec_t v;
    v.i = i; v.c = c; v.r = r; v.eo = eo; v.es = es; v.eb = eb;
    vecs.push_back(v);
  endtask

  // Drive on the falling edge; the expectation is for the following rising edge.
  task automatic drive(input logic i, input logic c, input logic r,
                       input logic eo, input logic es, input logic [1:0] eb);
    exp_t e;
    @(negedge clk);
    in_r    = i;
    clear_r = c;
    rst_n   = r;
    step_no++;
    e.eo = eo; e.es = es; e.eb = eb; e.id = step_no;
    exp_q.push_back(e);
  endtask

  // Two-cycle glitch from S_LOW; optional clear on the abort edge.
  task automatic glitch2(input logic [1:0] b_before, input logic [1:0] b_after,
                         input logic clr);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, b_before);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, b_before);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, b_before);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, b_before);
    drive(1'b0, clr,  1'b1, 1'b0, 1'b1, b_after);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      checks++;
      if (out !== cur.eo) begin
        errors++;
        $display("FAIL step %0d out: got %b expected %b", cur.id, out, cur.eo);
      end
      checks++;
      if (stable !== cur.es) begin
        errors++;
        $display("FAIL step %0d stable: got %b expected %b", cur.id, stable, cur.es);
      end
      checks++;
      if (bc !== cur.eb) begin
        errors++;
        $display("FAIL step %0d bounce_count: got %0d expected %0d", cur.id, bc, cur.eb);
      end
      $display("step %0d: out=%b stable=%b bounce_count=%0d", cur.id, out, stable, bc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset then idle.
    for (int k = 0; k < 2; k++) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    for (int k = 0; k < 10; k++) add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    // Clean rise: out at edge 6, stable low for edges 3..5.
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
    // Bouncy release 1,0,1,0,0,0,0: one aborted fall, then fall 6 edges after last 1->0.
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1);
    // Clear, then a 3-sample pulse that aborts.
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1);
    // Single-cycle glitch.
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2);

    foreach (vecs[k]) drive(vecs[k].i, vecs[k].c, vecs[k].r,
                            vecs[k].eo, vecs[k].es, vecs[k].eb);

    // Saturation: five 2-cycle glitches, then a sixth whose abort meets clear.
    glitch2(2'd2, 2'd3, 1'b0);
    glitch2(2'd3, 2'd3, 1'b0);
    glitch2(2'd3, 2'd3, 1'b0);
    glitch2(2'd3, 2'd3, 1'b0);
    glitch2(2'd3, 2'd3, 1'b0);
    glitch2(2'd3, 2'd0, 1'b1);

    // Reset mid-qualification, then full requalification with in still high.
    glitch2(2'd0, 2'd1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
